row_programmer: RTL

Downstream sequencer for the row-format convertor. Walks every logical row of the coupling array and drives its index into the convertor. Captures the returned 184-bit accelerator row image and physical row address, then streams the image bit-serially into the accelerator's weight scan chain. Issues one write strobe per row so the chip latches the row at its physical address.

---
 rtl/row_programmer.sv | 102 ++++++++++
 1 files changed

// File: rtl/row_programmer.sv
// row_programmer: fetches each logical row from the convertor, scans its image out MSB first, then strobes its physical address.
// Optional feature: define ROW_PROG_PARITY_EN to append an even-parity beat to every row.
module row_programmer #(
   parameter int NUM_ROWS = 46,
   parameter int ADDR_W   = 6,
   parameter int ROW_W    = 184
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] row_idx,
   input  logic [ROW_W-1:0]  row_data,
   input  logic [ADDR_W-1:0] row_addr_phys,
   output logic              scan_out,
   output logic              scan_valid,
   input  logic              scan_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              busy,
   output logic              done
);
`ifdef ROW_PROG_PARITY_EN
   localparam int SR_W = ROW_W + 1;
`else
   localparam int SR_W = ROW_W;
`endif
   localparam int CW = $clog2(ROW_W + 1);

   typedef enum logic [2:0] {IDLE, FETCH, SHIFT, COMMIT, DONE} state_t;

   state_t            state;
   logic [SR_W-1:0]   sr;
   logic [SR_W-1:0]   load;
   logic [ADDR_W-1:0] addr_q;
   logic [CW-1:0]     cnt;

`ifdef ROW_PROG_PARITY_EN
   assign load = {row_data, ^row_data};
`else
   assign load = row_data;
`endif
   // Zero fill drains the register to 0 by the end of each row, so the MSB is 0 whenever idle.
   assign scan_out = sr[SR_W-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sr         <= '0;
         addr_q     <= '0;
         cnt        <= '0;
         row_idx    <= '0;
         scan_valid <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state   <= FETCH;
               busy    <= 1'b1;
               row_idx <= '0;
            end
            FETCH: begin
               sr         <= load;
               addr_q     <= row_addr_phys;
               cnt        <= '0;
               scan_valid <= 1'b1;
               state      <= SHIFT;
            end
            SHIFT: if (scan_ready) begin
               sr  <= sr << 1;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(SR_W - 1)) begin
                  scan_valid <= 1'b0;
                  wr_en      <= 1'b1;
                  wr_addr    <= addr_q;
                  state      <= COMMIT;
               end
            end
            COMMIT: begin
               wr_en   <= 1'b0;
               wr_addr <= '0;
               if (row_idx == ADDR_W'(NUM_ROWS - 1)) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  row_idx <= row_idx + ADDR_W'(1);
                  state   <= FETCH;
               end
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               row_idx <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
